// File: rtl/predistort_pkg.sv
// -----------------------------------------------------------------------------
// predistort_pkg
// Shared definitions for the predistorter tap-table controller. The NoC
// settings block and the readback mux use the same package:
//   - SR_* register offsets, relative to the owner's SR_BASE
//   - FSM state encoding of the tap streamer
//   - bit positions of the 32-bit status readback word
//   - helpers: lowest-set-bit channel pick, one-hot decode, status packing
// -----------------------------------------------------------------------------
package predistort_pkg;

    // Widest channel mask the controller supports.
    localparam int MAX_CHANNELS = 4;
    localparam int CHAN_W       = 2;

    // Settings-register offsets from SR_BASE.
    localparam int SR_TAP_DATA  = 0;
    localparam int SR_TAP_CLEAR = 1;
    localparam int SR_COMMIT    = 2;

    // Streamer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_STREAM = 2'd2,
        ST_NEXT   = 2'd3
    } tap_state_t;

    // Status word layout:
    // {overflow, reject, busy, 5'b0, cur_chan[7:0], count[15:0]}.
    localparam int STATUS_OVERFLOW_BIT = 31;
    localparam int STATUS_REJECT_BIT   = 30;
    localparam int STATUS_BUSY_BIT     = 29;
    localparam int STATUS_CHAN_LSB     = 16;
    localparam int STATUS_COUNT_LSB    = 0;

    // Index of the lowest set bit. Returns 0 for an empty mask; callers only
    // use it on a non-empty mask.
    function automatic logic [CHAN_W-1:0] lowest_set_bit(input logic [MAX_CHANNELS-1:0] mask);
        logic [CHAN_W-1:0] idx;
        idx = '0;
        for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = CHAN_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [MAX_CHANNELS-1:0] chan_onehot(input logic [CHAN_W-1:0] chan);
        logic [MAX_CHANNELS-1:0] oh;
        oh       = '0;
        oh[chan] = 1'b1;
        return oh;
    endfunction

    function automatic logic [31:0] pack_status(
        input logic        overflow,
        input logic        reject,
        input logic        busy,
        input logic [7:0]  chan,
        input logic [15:0] count
    );
        logic [31:0] word;
        word                                       = '0;
        word[STATUS_OVERFLOW_BIT]                  = overflow;
        word[STATUS_REJECT_BIT]                    = reject;
        word[STATUS_BUSY_BIT]                      = busy;
        word[STATUS_CHAN_LSB +: 8]                 = chan;
        word[STATUS_COUNT_LSB +: 16]               = count;
        return word;
    endfunction

endpackage

// File: rtl/predistort_tap_ram.sv
// -----------------------------------------------------------------------------
// predistort_tap_ram
// Staging table for predistorter taps: 2^DEPTH entries x 16 bits.
// Synchronous write, combinational read, so the streamer can load its output
// register in the same cycle it presents the read address.
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write index
//   wr_data  : tap value to store
//   rd_addr  : read index
//   rd_data  : tap value at rd_addr (combinational)
// Contents are not reset.
// -----------------------------------------------------------------------------
module predistort_tap_ram #(
    parameter int DEPTH = 7
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [DEPTH-1:0] wr_addr,
    input  logic [15:0]      wr_data,
    input  logic [DEPTH-1:0] rd_addr,
    output logic [15:0]      rd_data
);

    logic [15:0] mem [0:(1<<DEPTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/predistort_taps_ctrl.sv
// -----------------------------------------------------------------------------
// predistort_taps_ctrl
// Collects predistorter taps from the settings bus into a staging table, then
// streams the whole table to each channel selected by a commit mask. Channels
// are served one at a time in ascending order.
//   clk, reset          : clock, asynchronous active-high reset
//   set_stb/addr/data   : settings bus (SR_BASE+0 data, +1 clear, +2 commit)
//   taps_tdata          : 16-bit tap per channel, lane k = bits [16k+15:16k]
//   taps_tvalid/tlast   : per-channel stream handshake, only cur_chan active
//   taps_tready         : per-channel backpressure
//   busy                : a load is in progress (FSM not idle)
//   status              : {overflow, reject, busy, 5'b0, cur_chan, count}
// Timing: commit strobe cycle -> SELECT cycle -> first beat, so tvalid rises
// two cycles after the strobe cycle; between channels, NEXT and SELECT leave a
// two-cycle gap.
// -----------------------------------------------------------------------------
module predistort_taps_ctrl
    import predistort_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int DEPTH        = 7,
    parameter int SR_BASE      = 130
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      set_stb,
    input  logic [7:0]                set_addr,
    input  logic [31:0]               set_data,
    output logic [16*NUM_CHANNELS-1:0] taps_tdata,
    output logic [NUM_CHANNELS-1:0]   taps_tlast,
    output logic [NUM_CHANNELS-1:0]   taps_tvalid,
    input  logic [NUM_CHANNELS-1:0]   taps_tready,
    output logic                      busy,
    output logic [31:0]               status
);

    localparam int NUM_TAPS = 1 << DEPTH;
    // One extra bit so count can hold NUM_TAPS itself (table full).
    localparam int CNT_W    = DEPTH + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT     = CNT_W'(NUM_TAPS);
    localparam logic [7:0]       ADDR_TAP_DATA  = 8'(SR_BASE + SR_TAP_DATA);
    localparam logic [7:0]       ADDR_TAP_CLEAR = 8'(SR_BASE + SR_TAP_CLEAR);
    localparam logic [7:0]       ADDR_COMMIT    = 8'(SR_BASE + SR_COMMIT);

    tap_state_t              state_reg;
    logic [CNT_W-1:0]        count_reg;
    logic [CNT_W-1:0]        rd_ptr_reg;
    logic [NUM_CHANNELS-1:0] pending_reg;
    logic [CHAN_W-1:0]       cur_chan_reg;
    logic                    overflow_reg;
    logic                    reject_reg;
    logic [15:0]             tdata_reg;
    logic [NUM_CHANNELS-1:0] tvalid_reg;
    logic [NUM_CHANNELS-1:0] tlast_reg;

    // Settings decode
    logic                    do_tap;
    logic                    do_clear;
    logic                    do_commit;
    logic                    is_idle;
    logic [NUM_CHANNELS-1:0] commit_mask;
    logic                    commit_ok;

    assign do_tap      = set_stb && (set_addr == ADDR_TAP_DATA);
    assign do_clear    = set_stb && (set_addr == ADDR_TAP_CLEAR);
    assign do_commit   = set_stb && (set_addr == ADDR_COMMIT);
    assign is_idle     = (state_reg == ST_IDLE);
    assign commit_mask = set_data[NUM_CHANNELS-1:0];
    assign commit_ok   = do_commit && is_idle && (count_reg != '0) && (|commit_mask);

    // Staging table. Writes are only accepted while idle, so the table is
    // frozen for the duration of a load.
    logic              ram_we;
    logic [DEPTH-1:0]  ram_raddr;
    logic [15:0]       ram_rdata;
    logic [CNT_W-1:0]  rd_next;
    logic [CNT_W-1:0]  last_idx;

    assign ram_we    = do_tap && is_idle && (count_reg != FULL_COUNT);
    assign rd_next   = rd_ptr_reg + CNT_W'(1);
    assign last_idx  = count_reg - CNT_W'(1);
    // SELECT preloads entry 0; in STREAM the read port looks one entry ahead
    // so the output register can advance on every handshake.
    assign ram_raddr = (state_reg == ST_SELECT) ? '0 : rd_next[DEPTH-1:0];

    predistort_tap_ram #(
        .DEPTH (DEPTH)
    ) u_tap_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (count_reg[DEPTH-1:0]),
        .wr_data (set_data[15:0]),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    // Channel selection
    logic [MAX_CHANNELS-1:0] pending_wide;
    logic [CHAN_W-1:0]       sel_chan;
    logic [MAX_CHANNELS-1:0] sel_onehot_wide;
    logic [NUM_CHANNELS-1:0] sel_onehot;
    logic [MAX_CHANNELS-1:0] cur_onehot_wide;
    logic [NUM_CHANNELS-1:0] cur_onehot;
    logic                    handshake;

    assign pending_wide    = MAX_CHANNELS'(pending_reg);
    assign sel_chan        = lowest_set_bit(pending_wide);
    assign sel_onehot_wide = chan_onehot(sel_chan);
    assign sel_onehot      = sel_onehot_wide[NUM_CHANNELS-1:0];
    assign cur_onehot_wide = chan_onehot(cur_chan_reg);
    assign cur_onehot      = cur_onehot_wide[NUM_CHANNELS-1:0];
    // tvalid_reg is one-hot on cur_chan, so this is the selected ready.
    assign handshake       = |(tvalid_reg & taps_tready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            pending_reg  <= '0;
            cur_chan_reg <= '0;
            overflow_reg <= 1'b0;
            reject_reg   <= 1'b0;
            tdata_reg    <= '0;
            tvalid_reg   <= '0;
            tlast_reg    <= '0;
        end else begin
            // Settings bus. Only one address is decoded per strobe.
            if (do_tap) begin
                if (!is_idle) begin
                    reject_reg <= 1'b1;
                end else if (count_reg == FULL_COUNT) begin
                    overflow_reg <= 1'b1;
                end else begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end
            if (do_clear) begin
                if (!is_idle) begin
                    reject_reg <= 1'b1;
                end else begin
                    count_reg    <= '0;
                    overflow_reg <= 1'b0;
                    reject_reg   <= 1'b0;
                end
            end
            if (do_commit && !commit_ok) begin
                reject_reg <= 1'b1;
            end

            // Streamer
            case (state_reg)
                ST_IDLE: begin
                    if (commit_ok) begin
                        pending_reg <= commit_mask;
                        state_reg   <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    cur_chan_reg <= sel_chan;
                    rd_ptr_reg   <= '0;
                    tdata_reg    <= ram_rdata;
                    tvalid_reg   <= sel_onehot;
                    tlast_reg    <= (last_idx == '0) ? sel_onehot : '0;
                    state_reg    <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (handshake) begin
                        if (|tlast_reg) begin
                            tvalid_reg  <= '0;
                            tlast_reg   <= '0;
                            pending_reg <= pending_reg & ~cur_onehot;
                            state_reg   <= ST_NEXT;
                        end else begin
                            rd_ptr_reg <= rd_next;
                            tdata_reg  <= ram_rdata;
                            tlast_reg  <= (rd_next == last_idx) ? cur_onehot : '0;
                        end
                    end
                end
                ST_NEXT: begin
                    state_reg <= (pending_reg != '0) ? ST_SELECT : ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Only the active channel's lane carries data; every other lane is zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
            assign taps_tdata[16*gi +: 16] = tvalid_reg[gi] ? tdata_reg : 16'h0000;
        end
    endgenerate

    assign taps_tvalid = tvalid_reg;
    assign taps_tlast  = tlast_reg;
    assign busy        = !is_idle;
    assign status      = pack_status(overflow_reg, reject_reg, busy,
                                     8'(cur_chan_reg), 16'(count_reg));

    // Upper settings-data bits have no meaning for this block.
    logic unused_set_data;
    assign unused_set_data = ^set_data[31:16];

endmodule

// File: tb/tb_predistort_taps_ctrl.sv
module tb_predistort_taps_ctrl;

    localparam int NC       = 4;
    localparam int DEPTH    = 7;
    localparam int SR_BASE  = 130;
    localparam int NUM_TAPS = 128;

    logic          clk;
    logic          reset;
    logic          set_stb;
    logic [7:0]    set_addr;
    logic [31:0]   set_data;
    logic [16*NC-1:0] taps_tdata;
    logic [NC-1:0] taps_tlast;
    logic [NC-1:0] taps_tvalid;
    logic [NC-1:0] taps_tready;
    logic          busy;
    logic [31:0]   status;

    predistort_taps_ctrl #(
        .NUM_CHANNELS (NC),
        .DEPTH        (DEPTH),
        .SR_BASE      (SR_BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .set_stb     (set_stb),
        .set_addr    (set_addr),
        .set_data    (set_data),
        .taps_tdata  (taps_tdata),
        .taps_tlast  (taps_tlast),
        .taps_tvalid (taps_tvalid),
        .taps_tready (taps_tready),
        .busy        (busy),
        .status      (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking bookkeeping ----------------
    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          chan;
        logic [15:0] data;
        bit          last;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] m_tab[$];
    bit          m_ov = 0;
    bit          m_rj = 0;
    int          m_cur = 0;

    function automatic logic [31:0] exp_status();
        return {m_ov, m_rj, 1'b0, 5'b0, 8'(m_cur), 16'(m_tab.size())};
    endfunction

    // ---------------- monitor state ----------------
    bit   awaiting_first = 0;
    bit   in_chan = 0;
    int   commit_cyc = 0;
    int   last_hs_cyc = 0;
    int   busy_chk_cyc = -10;
    int   beats_hs = 0;
    int   lasts_seen = 0;
    bit   stall_prev = 0;
    logic [16*NC+2*NC-1:0] prev_out;
    beat_t       mb;
    logic [NC-1:0]    ev;
    logic [16*NC-1:0] ed;

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (stall_prev)
                check_eq("stable_while_stalled", 128'({taps_tvalid, taps_tlast, taps_tdata}), 128'(prev_out));
            if (cyc == busy_chk_cyc + 1) check_eq("busy_in_next", 128'(busy), 128'(1));
            if (cyc == busy_chk_cyc + 2) check_eq("busy_after_next", 128'(busy), 128'(0));
            if (taps_tvalid != '0 && exp_q.size() == 0) begin
                check_eq("unexpected_tvalid", 128'(taps_tvalid), 128'(0));
            end else if (taps_tvalid != '0) begin
                if (!in_chan) begin
                    in_chan = 1;
                    if (awaiting_first) begin
                        check_eq("commit_latency", 128'(cyc - commit_cyc), 128'(2));
                        awaiting_first = 0;
                    end else begin
                        check_eq("chan_gap", 128'(cyc - last_hs_cyc), 128'(3));
                    end
                end
                if (|(taps_tvalid & taps_tready)) begin
                    mb = exp_q.pop_front();
                    ev = NC'(1) << mb.chan;
                    ed = (16*NC)'(mb.data) << (16 * mb.chan);
                    check_eq("beat", 128'({taps_tvalid, taps_tlast, taps_tdata}),
                             128'({ev, (mb.last ? ev : NC'(0)), ed}));
                    beats_hs++;
                    if (|(taps_tlast & taps_tvalid & taps_tready)) lasts_seen++;
                    if (mb.last) begin
                        in_chan = 0;
                        last_hs_cyc = cyc;
                        if (exp_q.size() == 0) busy_chk_cyc = cyc;
                    end
                end
            end
            stall_prev = (taps_tvalid != '0) && !(|(taps_tvalid & taps_tready));
            prev_out   = {taps_tvalid, taps_tlast, taps_tdata};
        end
    end

    // ---------------- tready driver ----------------
    int ready_mode = 0;
    initial begin
        taps_tready = '1;
        forever begin
            @(posedge clk);
            #1;
            taps_tready = (ready_mode != 0) ? NC'($urandom_range(0, 15)) : '1;
        end
    end

    // ---------------- stimulus tasks (entered at posedge+1) ----------------
    task automatic sr_write(input int ofs, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = 8'(SR_BASE + ofs);
        set_data = d;
        @(posedge clk);
        #1;
        set_stb  = 1'b0;
    endtask

    task automatic write_tap(input logic [15:0] v, input bit during_busy);
        if (during_busy) m_rj = 1;
        else if (m_tab.size() == NUM_TAPS) m_ov = 1;
        else m_tab.push_back(v);
        sr_write(0, {16'($urandom), v});
    endtask

    task automatic clear_taps(input bit during_busy);
        if (during_busy) m_rj = 1;
        else begin
            m_tab.delete();
            m_ov = 0;
            m_rj = 0;
        end
        sr_write(1, $urandom);
    endtask

    task automatic commit(input logic [31:0] mask, input bit during_busy);
        logic [NC-1:0] eff;
        beat_t b;
        eff = mask[NC-1:0];
        if (during_busy || m_tab.size() == 0 || eff == '0) begin
            m_rj = 1;
        end else begin
            for (int ch = 0; ch < NC; ch++) begin
                if (eff[ch]) begin
                    for (int i = 0; i < m_tab.size(); i++) begin
                        b.chan = ch;
                        b.data = m_tab[i];
                        b.last = (i == m_tab.size() - 1);
                        exp_q.push_back(b);
                    end
                    m_cur = ch;
                end
            end
            awaiting_first = 1;
            commit_cyc = cyc;
        end
        sr_write(2, mask);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check_eq("wait_idle_timeout", 128'(n), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string name);
        check_eq(name, 128'(status), 128'(exp_status()));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int n;
        reset    = 1'b1;
        set_stb  = 1'b0;
        set_addr = '0;
        set_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("tvalid_in_reset", 128'(taps_tvalid), 128'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("status_after_reset", 128'(status), 128'(0));
        check_eq("busy_after_reset", 128'(busy), 128'(0));
        check_eq("tdata_after_reset", 128'(taps_tdata), 128'(0));

        // Four taps to channel 0.
        clear_taps(0);
        for (int i = 0; i < 4; i++) write_tap(16'h0011 + 16'(i), 0);
        check_status("status_4taps");
        commit(32'h1, 0);
        wait_idle(200);
        check_status("status_after_ch0");

        // Same taps to channels 1 and 3; then upper mask bits ignored.
        commit(32'hA, 0);
        wait_idle(200);
        check_status("status_after_ch1_ch3");
        commit(32'hFFF0_0004, 0);
        wait_idle(200);
        check_status("status_after_ch2");

        // Full 128-tap load with random backpressure.
        clear_taps(0);
        for (int i = 0; i < NUM_TAPS; i++) write_tap(16'($urandom), 0);
        ready_mode = 1;
        base = lasts_seen;
        commit(32'h1, 0);
        wait_idle(3000);
        ready_mode = 0;
        check_eq("one_tlast_128", 128'(lasts_seen - base), 128'(1));
        check_status("status_after_128");

        // Overflow: 129 writes keep 128 entries.
        clear_taps(0);
        for (int i = 0; i < NUM_TAPS + 1; i++) write_tap(16'($urandom), 0);
        check_status("status_overflow");
        commit(32'h4, 0);
        wait_idle(1000);
        clear_taps(0);
        check_status("status_cleared");

        // Rejects: empty commit, then writes/clear/commit while busy.
        commit(32'h1, 0);
        repeat (6) @(posedge clk);
        #1;
        check_status("status_reject_empty");
        clear_taps(0);
        for (int i = 0; i < 4; i++) write_tap(16'($urandom), 0);
        commit(32'h3, 0);
        write_tap(16'hDEAD, 1);
        clear_taps(1);
        commit(32'h8, 1);
        wait_idle(300);
        check_status("status_reject_busy");

        // Random loads.
        for (int k = 0; k < 6; k++) begin
            clear_taps(0);
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) write_tap(16'($urandom), 0);
            ready_mode = $urandom_range(0, 1);
            commit({28'($urandom), 4'($urandom_range(1, 15))}, 0);
            wait_idle(500);
            ready_mode = 0;
            check_status("status_random_load");
        end

        // Reset on the third beat of a load.
        clear_taps(0);
        for (int i = 0; i < 4; i++) write_tap(16'h0011 + 16'(i), 0);
        base = beats_hs;
        commit(32'h1, 0);
        n = 0;
        while (beats_hs < base + 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) check_eq("reset_wait_timeout", 128'(n), 128'(0));
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("tvalid_drop_on_reset", 128'(taps_tvalid), 128'(0));
        check_eq("busy_drop_on_reset", 128'(busy), 128'(0));
        exp_q.delete();
        m_tab.delete();
        m_ov = 0;
        m_rj = 0;
        m_cur = 0;
        awaiting_first = 0;
        in_chan = 0;
        stall_prev = 0;
        busy_chk_cyc = -10;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("status_zero_after_midload_reset", 128'(status), 128'(0));
        for (int i = 0; i < 4; i++) write_tap(16'h0100 + 16'(i), 0);
        commit(32'h3, 0);
        wait_idle(300);
        check_status("status_after_reload");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before 500000");
        $fatal(1, "global timeout");
    end

endmodule
